// File: rtl/qspi_arb_pkg.sv
// rtl/qspi_arb_pkg.sv - shared encodings for the two-master QSPI memory arbiter
package qspi_arb_pkg;

    // Transfer size encoding shared by both masters and the controller port
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;

    // Read data returned to a master whose transaction was aborted by the watchdog
    localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    // A port requests whenever either size field is not SZ_NONE
    function automatic logic is_req(input logic [1:0] write_n, input logic [1:0] read_n);
        return (write_n != SZ_NONE) || (read_n != SZ_NONE);
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - combinational two-way round-robin pick
module arb_rr2
    import qspi_arb_pkg::*;
(
    input  logic  req_a,
    input  logic  req_b,
    input  port_t last_grant,
    output logic  grant_valid,
    output port_t grant
);

    // On a tie the port that did not win last time is chosen
    always_comb begin
        grant_valid = req_a | req_b;
        grant       = PORT_A;
        if (req_a && req_b) begin
            grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            grant = PORT_B;
        end
    end

endmodule

// File: rtl/qspi_mem_arbiter.sv
// rtl/qspi_mem_arbiter.sv - round-robin arbiter sharing one memory controller port
module qspi_mem_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int ADDR_W    = 25,
    parameter int TIMEOUT_W = 8
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic [ADDR_W-1:0] a_addr,
    input  logic [1:0]        a_write_n,
    input  logic [1:0]        a_read_n,
    input  logic [31:0]       a_wdata,
    output logic              a_ready,
    output logic [31:0]       a_rdata,

    input  logic [ADDR_W-1:0] b_addr,
    input  logic [1:0]        b_write_n,
    input  logic [1:0]        b_read_n,
    input  logic [31:0]       b_wdata,
    output logic              b_ready,
    output logic [31:0]       b_rdata,

    output logic [ADDR_W-1:0] m_addr,
    output logic [1:0]        m_write_n,
    output logic [1:0]        m_read_n,
    output logic [31:0]       m_wdata,
    input  logic              m_ready,
    input  logic [31:0]       m_rdata,

    output logic              timeout_err
);

    // Timer value seen during the last permitted BUSY cycle (2**TIMEOUT_W-1 cycles total).
    // TIMEOUT_W must be at least 2.
    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    arb_state_t           state, state_nxt;
    port_t                owner, owner_nxt;
    port_t                last_grant, last_grant_nxt;
    logic [TIMEOUT_W-1:0] timer, timer_nxt;

    logic [ADDR_W-1:0]    m_addr_nxt;
    logic [1:0]           m_write_n_nxt;
    logic [1:0]           m_read_n_nxt;
    logic [31:0]          m_wdata_nxt;
    logic                 a_ready_nxt, b_ready_nxt;
    logic [31:0]          a_rdata_nxt, b_rdata_nxt;
    logic                 timeout_err_nxt;

    logic                 req_a, req_b;
    logic                 grant_valid;
    port_t                grant;
    logic [1:0]           a_read_eff, b_read_eff;
    logic [ADDR_W-1:0]    sel_addr;
    logic [1:0]           sel_write_n;
    logic [1:0]           sel_read_n;
    logic [31:0]          sel_wdata;
    logic                 timer_hit;
    logic                 finish_busy;
    logic [31:0]          resp_data;

    // A port driving both a write and a read is treated as a write only
    always_comb begin
        a_read_eff = (a_write_n != SZ_NONE) ? SZ_NONE : a_read_n;
        b_read_eff = (b_write_n != SZ_NONE) ? SZ_NONE : b_read_n;
        req_a      = is_req(a_write_n, a_read_n);
        req_b      = is_req(b_write_n, b_read_n);
    end

    arb_rr2 u_arb (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Request fields of whichever port the arbiter picks this cycle
    always_comb begin
        if (grant == PORT_A) begin
            sel_addr    = a_addr;
            sel_write_n = a_write_n;
            sel_read_n  = a_read_eff;
            sel_wdata   = a_wdata;
        end else begin
            sel_addr    = b_addr;
            sel_write_n = b_write_n;
            sel_read_n  = b_read_eff;
            sel_wdata   = b_wdata;
        end
    end

    // Completion beats the watchdog when both land in the same cycle
    always_comb begin
        timer_hit   = (timer == TIMER_LAST);
        finish_busy = (state == BUSY) && (m_ready || timer_hit);
        resp_data   = m_ready ? m_rdata : TIMEOUT_DATA;
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> BUSY -> RELEASE -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = BUSY;
            BUSY:    if (finish_busy) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered controller request and master responses
    always_comb begin
        m_addr_nxt      = m_addr;
        m_write_n_nxt   = m_write_n;
        m_read_n_nxt    = m_read_n;
        m_wdata_nxt     = m_wdata;
        owner_nxt       = owner;
        last_grant_nxt  = last_grant;
        timer_nxt       = timer;
        a_ready_nxt     = 1'b0;
        b_ready_nxt     = 1'b0;
        a_rdata_nxt     = a_rdata;
        b_rdata_nxt     = b_rdata;
        timeout_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    m_addr_nxt     = sel_addr;
                    m_write_n_nxt  = sel_write_n;
                    m_read_n_nxt   = sel_read_n;
                    m_wdata_nxt    = sel_wdata;
                    owner_nxt      = grant;
                    last_grant_nxt = grant;
                    timer_nxt      = '0;
                end
            end
            BUSY: begin
                if (finish_busy) begin
                    m_write_n_nxt   = SZ_NONE;
                    m_read_n_nxt    = SZ_NONE;
                    timeout_err_nxt = !m_ready;
                    if (owner == PORT_A) begin
                        a_ready_nxt = 1'b1;
                        a_rdata_nxt = resp_data;
                    end else begin
                        b_ready_nxt = 1'b1;
                        b_rdata_nxt = resp_data;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset clears the controller request immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_addr      <= '0;
            m_write_n   <= SZ_NONE;
            m_read_n    <= SZ_NONE;
            m_wdata     <= '0;
            owner       <= PORT_A;
            last_grant  <= PORT_B;
            timer       <= '0;
            a_ready     <= 1'b0;
            b_ready     <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            m_addr      <= m_addr_nxt;
            m_write_n   <= m_write_n_nxt;
            m_read_n    <= m_read_n_nxt;
            m_wdata     <= m_wdata_nxt;
            owner       <= owner_nxt;
            last_grant  <= last_grant_nxt;
            timer       <= timer_nxt;
            a_ready     <= a_ready_nxt;
            b_ready     <= b_ready_nxt;
            a_rdata     <= a_rdata_nxt;
            b_rdata     <= b_rdata_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// tb/tb_qspi_mem_arbiter.sv - scoreboard bench for qspi_mem_arbiter
module tb_qspi_mem_arbiter;

    localparam int ADDR_W = 25;
    localparam int TW     = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [ADDR_W-1:0] a_addr, b_addr, m_addr;
    logic [1:0]        a_write_n, a_read_n, b_write_n, b_read_n, m_write_n, m_read_n;
    logic [31:0]       a_wdata, b_wdata, m_wdata, a_rdata, b_rdata, m_rdata;
    logic              a_ready, b_ready, m_ready, timeout_err;

    always #5 clk = ~clk;

    qspi_mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_W(TW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .a_addr      (a_addr),
        .a_write_n   (a_write_n),
        .a_read_n    (a_read_n),
        .a_wdata     (a_wdata),
        .a_ready     (a_ready),
        .a_rdata     (a_rdata),
        .b_addr      (b_addr),
        .b_write_n   (b_write_n),
        .b_read_n    (b_read_n),
        .b_wdata     (b_wdata),
        .b_ready     (b_ready),
        .b_rdata     (b_rdata),
        .m_addr      (m_addr),
        .m_write_n   (m_write_n),
        .m_read_n    (m_read_n),
        .m_wdata     (m_wdata),
        .m_ready     (m_ready),
        .m_rdata     (m_rdata),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        wn;
        logic [1:0]        rn;
        logic [31:0]       wdata;
    } req_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        to;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int compared = 0;
    int mismatched = 0;

    int          ctrl_delay = 0;
    logic [31:0] ctrl_data = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        compared++;
        mismatched++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic exp_req(input logic [ADDR_W-1:0] addr, input logic [1:0] wn,
                           input logic [1:0] rn, input logic [31:0] wd);
        req_t r;
        r.addr = addr; r.wn = wn; r.rn = rn; r.wdata = wd;
        req_q.push_back(r);
    endtask

    task automatic exp_rsp(input logic port, input logic [31:0] data, input logic to);
        rsp_t r;
        r.port = port; r.rdata = data; r.to = to;
        rsp_q.push_back(r);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input int n, input int budget);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            @(negedge clk);
            t++;
            if (a_ready || b_ready) seen++;
        end
        if (seen < n) flag("wait_ready", $sformatf("saw %0d ready pulses, required %0d", seen, n));
    endtask

    // Controller model: answers after ctrl_delay BUSY cycles (0 = never answers)
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        m_ready = 1'b0;
        m_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rstn && (m_read_n != 2'b11 || m_write_n != 2'b11)) begin
                busy_cnt++;
                if (busy_cnt == ctrl_delay) begin
                    m_ready = 1'b1;
                    m_rdata = ctrl_data;
                end else begin
                    m_ready = 1'b0;
                end
            end else begin
                busy_cnt = 0;
                m_ready = 1'b0;
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (a_ready && b_ready) flag("ready_onehot", "got a_ready=1 and b_ready=1, required at most one");
                if (a_ready || b_ready) begin
                    if (rsp_q.size() == 0) begin
                        flag("rsp_unexpected", $sformatf("got a_ready=%0b b_ready=%0b, required none", a_ready, b_ready));
                    end else begin
                        e = rsp_q.pop_front();
                        check("rsp_port", b_ready, e.port);
                        check("rsp_rdata", b_ready ? b_rdata : a_rdata, e.rdata);
                        check("rsp_timeout_err", timeout_err, e.to);
                    end
                end else if (timeout_err) begin
                    flag("timeout_no_ready", "got timeout_err=1 without ready, required 0");
                end
            end
        end
    end

    // Controller-side monitor: request contents, stability while busy, idle gap
    initial begin
        req_t e;
        int   idle_cnt;
        logic active, prev_active, have;
        idle_cnt = 100;
        prev_active = 1'b0;
        have = 1'b0;
        forever begin
            @(negedge clk);
            active = (m_read_n != 2'b11) || (m_write_n != 2'b11);
            if (active && !prev_active) begin
                check("idle_gap_ge2", idle_cnt >= 2, 1);
                if (req_q.size() == 0) begin
                    flag("req_unexpected", $sformatf("got request addr 0x%0h, required none", m_addr));
                    have = 1'b0;
                end else begin
                    e = req_q.pop_front();
                    have = 1'b1;
                end
            end
            if (active && have) begin
                check("m_addr", m_addr, e.addr);
                check("m_write_n", m_write_n, e.wn);
                check("m_read_n", m_read_n, e.rn);
                check("m_wdata", m_wdata, e.wdata);
            end
            if (active) idle_cnt = 0;
            else idle_cnt++;
            prev_active = active;
        end
    end

    initial begin
        a_addr = '0; a_write_n = 2'b11; a_read_n = 2'b11; a_wdata = '0;
        b_addr = '0; b_write_n = 2'b11; b_read_n = 2'b11; b_wdata = '0;
        rstn = 1'b0;
        cyc(2);
        check("rst_m_write_n", m_write_n, 2'b11);
        check("rst_m_read_n", m_read_n, 2'b11);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_ready", {a_ready, b_ready}, 2'b00);
        check("rst_rdata", {a_rdata, b_rdata}, 64'h0);
        check("rst_timeout_err", timeout_err, 0);
        rstn = 1'b1;
        cyc(2);

        // Single word read by A, answered on the third BUSY cycle
        ctrl_delay = 3; ctrl_data = 32'hDEAD_BEEF;
        a_addr = 25'h000100; a_read_n = 2'b10; a_wdata = 32'h0;
        exp_req(25'h000100, 2'b11, 2'b10, 32'h0);
        exp_rsp(1'b0, 32'hDEAD_BEEF, 1'b0);
        @(posedge clk); #1;
        check("t1_latency_read_n", m_read_n, 2'b10);
        a_read_n = 2'b11;
        wait_ready(1, 20);
        cyc(3);

        // B changes its address while BUSY; controller sees the original one
        ctrl_delay = 4; ctrl_data = 32'h0000_1234;
        b_addr = 25'h10; b_read_n = 2'b01; b_wdata = 32'h0;
        exp_req(25'h10, 2'b11, 2'b01, 32'h0);
        exp_rsp(1'b1, 32'h0000_1234, 1'b0);
        @(posedge clk); #1;
        b_addr = 25'h20; b_read_n = 2'b11;
        wait_ready(1, 20);
        cyc(3);

        // Write and read together: write wins, read forwarded as none
        ctrl_delay = 1; ctrl_data = 32'h0BAD_F00D;
        a_addr = 25'h40; a_write_n = 2'b00; a_read_n = 2'b10; a_wdata = 32'h0000_00AB;
        exp_req(25'h40, 2'b00, 2'b11, 32'h0000_00AB);
        exp_rsp(1'b0, 32'h0BAD_F00D, 1'b0);
        @(posedge clk); #1;
        check("t6_m_write_n", m_write_n, 2'b00);
        check("t6_m_read_n", m_read_n, 2'b11);
        a_write_n = 2'b11; a_read_n = 2'b11;
        wait_ready(1, 20);
        cyc(3);

        // Watchdog abort after 15 BUSY cycles
        ctrl_delay = 0; ctrl_data = 32'h0;
        a_addr = 25'h80; a_read_n = 2'b10; a_wdata = 32'h0;
        exp_req(25'h80, 2'b11, 2'b10, 32'h0);
        exp_rsp(1'b0, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        a_read_n = 2'b11;
        repeat (14) @(posedge clk);
        #1;
        check("t4_no_early_ready", a_ready, 0);
        @(posedge clk); #1;
        check("t4_abort_ready", a_ready, 1);
        check("t4_abort_err", timeout_err, 1);
        check("t4_abort_read_n", m_read_n, 2'b11);
        cyc(3);

        // Completion on the terminal-count cycle wins over the watchdog
        ctrl_delay = 15; ctrl_data = 32'h5555_AAAA;
        a_addr = 25'h84; a_read_n = 2'b10;
        exp_req(25'h84, 2'b11, 2'b10, 32'h0);
        exp_rsp(1'b0, 32'h5555_AAAA, 1'b0);
        @(posedge clk); #1;
        a_read_n = 2'b11;
        repeat (15) @(posedge clk);
        #1;
        check("t4b_ready", a_ready, 1);
        check("t4b_no_err", timeout_err, 0);
        check("t4b_rdata", a_rdata, 32'h5555_AAAA);
        cyc(3);

        // Reset asserted mid-BUSY
        ctrl_delay = 0;
        a_addr = 25'h500; a_read_n = 2'b10;
        exp_req(25'h500, 2'b11, 2'b10, 32'h0);
        @(posedge clk); #1;
        a_read_n = 2'b11;
        repeat (3) @(posedge clk);
        #3;
        check("t5_busy_before_rst", m_read_n, 2'b10);
        rstn = 1'b0;
        #1;
        check("t5_m_read_n", m_read_n, 2'b11);
        check("t5_m_write_n", m_write_n, 2'b11);
        check("t5_m_addr", m_addr, 0);
        check("t5_m_wdata", m_wdata, 0);
        check("t5_ready", {a_ready, b_ready}, 2'b00);
        check("t5_rdata", {a_rdata, b_rdata}, 64'h0);
        check("t5_timeout_err", timeout_err, 0);
        cyc(2);

        // Both ports request continuously from reset release: A,B,A,B
        ctrl_delay = 2; ctrl_data = 32'h600D_0002;
        a_addr = 25'h200; a_read_n = 2'b10; a_wdata = 32'h0;
        b_addr = 25'h300; b_write_n = 2'b10; b_read_n = 2'b11; b_wdata = 32'h1234_5678;
        exp_req(25'h200, 2'b11, 2'b10, 32'h0);
        exp_req(25'h300, 2'b10, 2'b11, 32'h1234_5678);
        exp_req(25'h200, 2'b11, 2'b10, 32'h0);
        exp_req(25'h300, 2'b10, 2'b11, 32'h1234_5678);
        exp_rsp(1'b0, 32'h600D_0002, 1'b0);
        exp_rsp(1'b1, 32'h600D_0002, 1'b0);
        exp_rsp(1'b0, 32'h600D_0002, 1'b0);
        exp_rsp(1'b1, 32'h600D_0002, 1'b0);
        rstn = 1'b1;
        wait_ready(4, 100);
        a_read_n = 2'b11; b_write_n = 2'b11;
        cyc(5);

        check("req_q_drained", req_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
